// File: rtl/tsi_cmd_engine_if.sv
// Handshake bundle between the serial bridge, the command engine and its memory port.
// The master modport is the engine side; slave is the bridge/memory side.
interface tsi_cmd_engine_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_bits;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_bits;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_data;
  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [31:0]       mem_resp_data;

  modport master (
    input  in_valid, in_bits, out_ready, mem_req_ready, mem_resp_valid, mem_resp_data,
    output in_ready, out_valid, out_bits, mem_req_valid, mem_req_write, mem_req_addr,
           mem_req_data, mem_resp_ready
  );

  modport slave (
    output in_valid, in_bits, out_ready, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  in_ready, out_valid, out_bits, mem_req_valid, mem_req_write, mem_req_addr,
           mem_req_data, mem_resp_ready
  );
endinterface

// File: rtl/tsi_cmd_engine.sv
// Target-side tethered-serial command engine: parses read/write commands from the host
// word stream, issues one word access at a time and returns read data to the host.
module tsi_cmd_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  tsi_cmd_engine_if.master      bus,
  output logic                  busy,
  output logic                  bad_cmd
);

  typedef enum logic [3:0] {
    StCmd,
    StAddrLo,
    StAddrHi,
    StLenLo,
    StLenHi,
    StWrData,
    StWrReq,
    StRdReq,
    StRdResp,
    StRdOut
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [31:0]         data_q, data_d;
  logic                is_write_q, is_write_d;
  logic                bad_cmd_q, bad_cmd_d;
  logic                accept;
  logic                in_fire;
  logic [63:0]         addr_full;
  logic [63:0]         len_full;
  logic [ADDR_W-1:0]   addr_next;

  // Data register doubles as the read-return register; only one of the two is live at a time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StCmd;
      addr_q     <= '0;
      count_q    <= '0;
      data_q     <= '0;
      is_write_q <= 1'b0;
      bad_cmd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      is_write_q <= is_write_d;
      bad_cmd_q  <= bad_cmd_d;
    end
  end

  always_comb begin
    accept = (state_q == StCmd)   || (state_q == StAddrLo) || (state_q == StAddrHi) ||
             (state_q == StLenLo) || (state_q == StLenHi)  || (state_q == StWrData);
    in_fire   = bus.in_valid & accept;
    addr_full = {bus.in_bits, 32'(addr_q)};
    len_full  = {bus.in_bits, 32'(count_q)};
    addr_next = addr_q + ADDR_W'(4);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    data_d     = data_q;
    is_write_d = is_write_q;
    bad_cmd_d  = bad_cmd_q;

    unique case (state_q)
      StCmd: begin
        if (in_fire) begin
          if (bus.in_bits == 32'd0) begin
            is_write_d = 1'b0;
            state_d    = StAddrLo;
          end else if (bus.in_bits == 32'd1) begin
            is_write_d = 1'b1;
            state_d    = StAddrLo;
          end else begin
            // Unknown command: swallow the word, stay here, remember it.
            bad_cmd_d = 1'b1;
          end
        end
      end
      StAddrLo: begin
        if (in_fire) begin
          addr_d  = ADDR_W'(bus.in_bits);
          state_d = StAddrHi;
        end
      end
      StAddrHi: begin
        if (in_fire) begin
          addr_d  = ADDR_W'(addr_full);
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (in_fire) begin
          count_d = LEN_W'(bus.in_bits);
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (in_fire) begin
          count_d = LEN_W'(len_full);
          state_d = is_write_q ? StWrData : StRdReq;
        end
      end
      StWrData: begin
        if (in_fire) begin
          data_d  = bus.in_bits;
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        if (bus.mem_req_ready) begin
          addr_d = addr_next;
          if (count_q == '0) begin
            state_d = StCmd;
          end else begin
            count_d = count_q - LEN_W'(1);
            state_d = StWrData;
          end
        end
      end
      StRdReq: begin
        if (bus.mem_req_ready) begin
          state_d = StRdResp;
        end
      end
      StRdResp: begin
        if (bus.mem_resp_valid) begin
          data_d  = bus.mem_resp_data;
          state_d = StRdOut;
        end
      end
      StRdOut: begin
        if (bus.out_ready) begin
          addr_d = addr_next;
          if (count_q == '0) begin
            state_d = StCmd;
          end else begin
            count_d = count_q - LEN_W'(1);
            state_d = StRdReq;
          end
        end
      end
      default: begin
        state_d = StCmd;
      end
    endcase
  end

  // Every output is a decode of state or a straight register copy.
  always_comb begin
    bus.in_ready       = accept;
    bus.mem_req_valid  = (state_q == StWrReq) || (state_q == StRdReq);
    bus.mem_req_write  = (state_q == StWrReq);
    bus.mem_req_addr   = addr_q;
    bus.mem_req_data   = data_q;
    bus.mem_resp_ready = (state_q == StRdResp);
    bus.out_valid      = (state_q == StRdOut);
    bus.out_bits       = data_q;
    busy               = (state_q != StCmd);
    bad_cmd            = bad_cmd_q;
  end

  a_req_stable: assert property (@(posedge clock) disable iff (reset)
    bus.mem_req_valid && !bus.mem_req_ready |=>
      bus.mem_req_valid && $stable(bus.mem_req_addr) && $stable(bus.mem_req_data) &&
      $stable(bus.mem_req_write));

  a_out_stable: assert property (@(posedge clock) disable iff (reset)
    bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_bits));

  a_single_outstanding: assert property (@(posedge clock) disable iff (reset)
    !(bus.mem_req_valid && bus.mem_resp_ready));

endmodule

// File: tb/tb_tsi_cmd_engine.sv
// Randomized scoreboard bench for tsi_cmd_engine: a word-level reference model queues
// expected memory requests and read returns; a monitor pops and compares on each handshake.
module tb_tsi_cmd_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic bad_cmd;

  always #5 clk = ~clk;

  tsi_cmd_engine_if bus ();

  tsi_cmd_engine dut (
    .clock   (clk),
    .reset   (rst),
    .bus     (bus),
    .busy    (busy),
    .bad_cmd (bad_cmd)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
  } req_t;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } out_t;

  req_t        exp_req[$];
  out_t        exp_out[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] tb_mem[logic [31:0]];
  logic [31:0] wdata_q[$];
  bit          exp_bad = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          req_hold = 0;
  int          out_hold = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endfunction

  // Host side: present one word and hold it until the engine takes it.
  task automatic send_word(input logic [31:0] w);
    bit done;
    done = 1'b0;
    if ($urandom_range(0, 4) == 0) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_bits  = w;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) fail_now("in_ready_timeout");
  endtask

  // Reference model: derive the whole expected transaction from the command words.
  task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] alo, input logic [31:0] ahi,
                         input logic [31:0] llo, input logic [31:0] lhi);
    int          n;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] wd[$];
    req_t        r;
    out_t        o;
    @(posedge clk);
    #1;
    if (cmd > 32'd1) begin
      exp_bad = 1'b1;
      send_word(cmd);
      return;
    end
    n = int'(llo) + 1;
    for (int i = 0; i < n; i++) begin
      a = alo + 32'(4 * i);
      if (cmd == 32'd1) begin
        d = (wdata_q.size() != 0) ? wdata_q.pop_front() : $urandom;
        wd.push_back(d);
        ref_mem[a] = d;
        r.wr = 1'b1; r.addr = a; r.data = d; r.last = (i == n - 1);
        exp_req.push_back(r);
      end else begin
        d = ref_mem.exists(a) ? ref_mem[a] : 32'd0;
        r.wr = 1'b0; r.addr = a; r.data = 32'd0; r.last = (i == n - 1);
        exp_req.push_back(r);
        o.data = d; o.last = (i == n - 1);
        exp_out.push_back(o);
      end
    end
    send_word(cmd);
    send_word(alo);
    send_word(ahi);
    send_word(llo);
    send_word(lhi);
    foreach (wd[i]) send_word(wd[i]);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_req.size() == 0 && exp_out.size() == 0) done = 1'b1;
    end
    if (!done) begin
      fail_now("idle_timeout");
      exp_req.delete();
      exp_out.delete();
    end
  endtask

  // Memory model: random accept/response timing, posted writes, in-order read data.
  initial begin
    logic [31:0] pend[$];
    int          held;
    bit          rf, wf, wr;
    logic [31:0] a, d;
    held = 0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      rf = bus.mem_resp_valid && bus.mem_resp_ready;
      wf = bus.mem_req_valid && bus.mem_req_ready;
      wr = bus.mem_req_write;
      a  = bus.mem_req_addr;
      d  = bus.mem_req_data;
      @(posedge clk);
      #1;
      if (rst) begin
        pend.delete();
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b0;
        held = 0;
        continue;
      end
      if (wf) begin
        if (wr) tb_mem[a] = d;
        else pend.push_back(tb_mem.exists(a) ? tb_mem[a] : 32'd0);
      end
      if (rf) bus.mem_resp_valid = 1'b0;
      if (!bus.mem_resp_valid && pend.size() != 0 && $urandom_range(0, 2) != 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = pend.pop_front();
      end
      if (req_hold > held) begin
        bus.mem_req_ready = 1'b0;
        if (bus.mem_req_valid) held++;
      end else begin
        bus.mem_req_ready = ($urandom_range(0, 3) != 0);
        if (req_hold == 0) held = 0;
      end
    end
  end

  // Bridge-side read-data sink.
  initial begin
    int held;
    held = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_hold > held) begin
        bus.out_ready = 1'b0;
        if (bus.out_valid) held++;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        if (out_hold == 0) held = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    bit          ps_req, ps_out, idle_chk;
    logic [31:0] pa, pd, po;
    logic        pw;
    req_t        r;
    out_t        o;
    ps_req = 1'b0; ps_out = 1'b0; idle_chk = 1'b0;
    pa = '0; pd = '0; po = '0; pw = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ps_req = 1'b0; ps_out = 1'b0; idle_chk = 1'b0;
        continue;
      end
      if (idle_chk) begin
        chk("busy_after_last", 32'(busy), 32'd0);
        idle_chk = 1'b0;
      end
      if (ps_req) begin
        chk("req_held_valid", 32'(bus.mem_req_valid), 32'd1);
        chk("req_held_addr", bus.mem_req_addr, pa);
        chk("req_held_data", bus.mem_req_data, pd);
        chk("req_held_write", 32'(bus.mem_req_write), 32'(pw));
      end
      if (ps_out) begin
        chk("out_held_valid", 32'(bus.out_valid), 32'd1);
        chk("out_held_bits", bus.out_bits, po);
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (exp_req.size() == 0) begin
          fail_now("unexpected_req");
        end else begin
          r = exp_req.pop_front();
          chk("req_write", 32'(bus.mem_req_write), 32'(r.wr));
          chk("req_addr", bus.mem_req_addr, r.addr);
          if (r.wr) chk("req_data", bus.mem_req_data, r.data);
          if (r.wr && r.last) idle_chk = 1'b1;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) begin
          fail_now("unexpected_out");
        end else begin
          o = exp_out.pop_front();
          chk("out_bits", bus.out_bits, o.data);
          if (o.last) idle_chk = 1'b1;
        end
      end
      ps_req = bus.mem_req_valid && !bus.mem_req_ready;
      ps_out = bus.out_valid && !bus.out_ready;
      pa = bus.mem_req_addr;
      pd = bus.mem_req_data;
      pw = bus.mem_req_write;
      po = bus.out_bits;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    logic [31:0] cmd, alo;
    int          kind;
    bus.in_valid = 1'b0;
    bus.in_bits  = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bad_cmd", 32'(bad_cmd), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_resp_ready", 32'(bus.mem_resp_ready), 32'd0);
    chk("rst_req_addr", bus.mem_req_addr, 32'd0);
    chk("rst_out_bits", bus.out_bits, 32'd0);

    // Directed write then read-back of two words.
    wdata_q.push_back(32'hAAAA0001);
    wdata_q.push_back(32'hBBBB0002);
    run_cmd(32'd1, 32'h1000, 32'd0, 32'd1, 32'd0);
    wait_idle();
    chk("write_bad_cmd", 32'(bad_cmd), 32'd0);
    chk("model_word0", ref_mem[32'h1000], 32'hAAAA0001);
    run_cmd(32'd0, 32'h1000, 32'd0, 32'd1, 32'd0);
    wait_idle();

    // Same read under forced backpressure on both sides.
    req_hold = 3;
    out_hold = 5;
    run_cmd(32'd0, 32'h1000, 32'd0, 32'd1, 32'd0);
    wait_idle();
    req_hold = 0;
    out_hold = 0;

    // Unknown command followed by a normal write.
    run_cmd(32'd7, 32'd0, 32'd0, 32'd0, 32'd0);
    wait_idle();
    chk("bad_cmd_set", 32'(bad_cmd), 32'd1);
    run_cmd(32'd1, 32'h2000, 32'd0, 32'd0, 32'd0);
    wait_idle();
    chk("bad_cmd_sticky", 32'(bad_cmd), 32'd1);

    // Address wrap with a nonzero upper address word.
    run_cmd(32'd1, 32'hFFFFFFFC, 32'd5, 32'd1, 32'd0);
    wait_idle();
    run_cmd(32'd0, 32'hFFFFFFFC, 32'd0, 32'd1, 32'd0);
    wait_idle();

    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 9));
      alo  = 32'h3000 + {$urandom_range(0, 31), 2'b00};
      if ($urandom_range(0, 7) == 0) alo = 32'hFFFFFFF0 + {$urandom_range(0, 3), 2'b00};
      if (kind == 0) cmd = 32'd2 + $urandom_range(0, 1000);
      else if (kind < 5) cmd = 32'd1;
      else cmd = 32'd0;
      run_cmd(cmd, alo, $urandom, $urandom_range(0, 4), ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom);
      wait_idle();
      chk("rand_bad_cmd", 32'(bad_cmd), 32'(exp_bad));
    end

    // Reset while stalled on the first of four read words.
    out_hold = 1000;
    run_cmd(32'd0, 32'h1000, 32'd0, 32'd3, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    if (!seen) fail_now("rd_out_timeout");
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    exp_req.delete();
    exp_out.delete();
    exp_bad = 1'b0;
    out_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_bad_cmd", 32'(bad_cmd), 32'd0);
    run_cmd(32'd1, 32'h4000, 32'd0, 32'd2, 32'd0);
    wait_idle();
    run_cmd(32'd0, 32'h4000, 32'd0, 32'd2, 32'd0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
